// File: rtl/udp_reset_sequencer.sv
// Reset bring-up sequencer: releases PHY, then MAC, then UDP-stack resets under lock/link supervision.
// Define UDP_RSTSEQ_TIMEOUT_EN to enable the link-wait timeout and retry counter.
module udp_reset_sequencer #(
  parameter int unsigned C_NUM_SYNC_REGS  = 3,
  parameter int unsigned C_STABLE_CYCLES  = 1024,
  parameter int unsigned C_HOLD_CYCLES    = 16,
  parameter int unsigned C_TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       link_up,
  input  logic       soft_reset,
  output logic       phy_reset,
  output logic       mac_reset,
  output logic       udp_reset,
  output logic       seq_done,
  output logic [2:0] state_out,
  output logic [3:0] retry_count
);

  localparam int unsigned MaxSh  = (C_STABLE_CYCLES > C_HOLD_CYCLES) ? C_STABLE_CYCLES
                                                                     : C_HOLD_CYCLES;
  localparam int unsigned MaxCnt = (C_TIMEOUT_CYCLES > MaxSh) ? C_TIMEOUT_CYCLES : MaxSh;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  localparam logic [CntW-1:0] HoldLd   = CntW'(C_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StableLd = CntW'(C_STABLE_CYCLES - 1);
`ifdef UDP_RSTSEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] LinkLd    = CntW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] RelinkMax = CntW'(C_TIMEOUT_CYCLES - C_HOLD_CYCLES);
`else
  localparam logic [CntW-1:0] LinkLd    = HoldLd;
`endif

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StPhyHold  = 3'd2,
    StWaitLink = 3'd3,
    StMacHold  = 3'd4,
    StUdpHold  = 3'd5,
    StRun      = 3'd6
  } state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       init_q, init_d;
  logic                       relink_q, relink_d;
  logic [C_NUM_SYNC_REGS-1:0] lock_sync_q, link_sync_q;
  logic                       lock_s, link_s, hold_met;
  logic                       phy_reset_q, mac_reset_q, udp_reset_q, seq_done_q;
`ifdef UDP_RSTSEQ_TIMEOUT_EN
  logic [3:0]                 retry_q, retry_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_sync_q <= '0;
      link_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[C_NUM_SYNC_REGS-2:0], pll_locked};
      link_sync_q <= {link_sync_q[C_NUM_SYNC_REGS-2:0], link_up};
    end
  end

  assign lock_s = lock_sync_q[C_NUM_SYNC_REGS-1];
  assign link_s = link_sync_q[C_NUM_SYNC_REGS-1];

  // After a link drop the MAC reset must stay asserted a full hold time before re-release.
`ifdef UDP_RSTSEQ_TIMEOUT_EN
  assign hold_met = !relink_q || (cnt_q <= RelinkMax);
`else
  assign hold_met = !relink_q || (cnt_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    init_d   = init_q;
    relink_d = relink_q;
`ifdef UDP_RSTSEQ_TIMEOUT_EN
    retry_d  = retry_q;
`endif
    if ((!lock_s && state_q inside {StPhyHold, StWaitLink, StMacHold, StUdpHold, StRun})
        || soft_reset) begin
      state_d  = StReset;
      cnt_d    = HoldLd;
      init_d   = 1'b0;
      relink_d = 1'b0;
    end else if (!link_s && state_q inside {StMacHold, StUdpHold, StRun}) begin
      state_d  = StWaitLink;
      cnt_d    = LinkLd;
      relink_d = 1'b1;
    end else begin
      unique case (state_q)
        StReset: begin
          // First cycle after hardware reset loads the hold count.
          if (init_q) begin
            cnt_d  = HoldLd;
            init_d = 1'b0;
          end else if (cnt_q == '0) begin
            state_d = StWaitLock;
            cnt_d   = StableLd;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StWaitLock: begin
          if (!lock_s)              cnt_d   = StableLd;
          else if (cnt_q == '0)     state_d = StPhyHold;
          else                      cnt_d   = cnt_q - CntW'(1);
        end
        StPhyHold: begin
          state_d  = StWaitLink;
          relink_d = 1'b0;
`ifdef UDP_RSTSEQ_TIMEOUT_EN
          cnt_d    = LinkLd;
`endif
        end
        StWaitLink: begin
          if (link_s && hold_met) begin
            state_d  = StMacHold;
            cnt_d    = HoldLd;
            relink_d = 1'b0;
`ifdef UDP_RSTSEQ_TIMEOUT_EN
          end else if (cnt_q == '0) begin
            state_d  = StReset;
            cnt_d    = HoldLd;
            relink_d = 1'b0;
            if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
`else
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
`endif
          end
        end
        StMacHold: begin
          if (cnt_q == '0) state_d = StUdpHold;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        StUdpHold: state_d = StRun;
        StRun:     state_d = StRun;
        default:   state_d = StReset;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      init_q      <= 1'b1;
      relink_q    <= 1'b0;
      phy_reset_q <= 1'b1;
      mac_reset_q <= 1'b1;
      udp_reset_q <= 1'b1;
      seq_done_q  <= 1'b0;
`ifdef UDP_RSTSEQ_TIMEOUT_EN
      retry_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      relink_q    <= relink_d;
      // Outputs decode the next state so they change on the same edge as state_out.
      phy_reset_q <= (state_d == StReset) || (state_d == StWaitLock);
      mac_reset_q <= !(state_d inside {StMacHold, StUdpHold, StRun});
      udp_reset_q <= !(state_d inside {StUdpHold, StRun});
      seq_done_q  <= (state_d == StRun);
`ifdef UDP_RSTSEQ_TIMEOUT_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign phy_reset = phy_reset_q;
  assign mac_reset = mac_reset_q;
  assign udp_reset = udp_reset_q;
  assign seq_done  = seq_done_q;
  assign state_out = state_q;
`ifdef UDP_RSTSEQ_TIMEOUT_EN
  assign retry_count = retry_q;
`else
  assign retry_count = 4'd0;
`endif

endmodule
